// File: rtl/rs_encode_pkg.sv
// Shared RS(255,223) constants and helpers for codeword line framing.
package rs_encode_pkg;

    localparam int unsigned RS_WORD_W       = 8;
    localparam int unsigned RS_N            = 255;
    localparam int unsigned RS_K            = 223;
    localparam int unsigned RS_PARITY_BYTES = RS_N - RS_K;

    typedef enum logic {
        ST_PASS = 1'b0,
        ST_TAIL = 1'b1
    } pack_state_e;

    // Data lines needed to carry RS_K message bytes.
    function automatic int unsigned codeword_num_lines(input int unsigned data_bytes);
        return (RS_K + data_bytes - 1) / data_bytes;
    endfunction

    // Message bytes present on the last (partial or full) data line.
    function automatic int unsigned codeword_last_line_bytes(input int unsigned data_bytes);
        return ((RS_K % data_bytes) == 0) ? data_bytes : (RS_K % data_bytes);
    endfunction

    // Output lines needed for the last data line's bytes plus all parity.
    function automatic int unsigned codeword_tail_lines(input int unsigned data_bytes);
        int unsigned tail_bytes;
        tail_bytes = codeword_last_line_bytes(data_bytes) + RS_PARITY_BYTES;
        return (tail_bytes + data_bytes - 1) / data_bytes;
    endfunction

    // Valid bytes on the final output line of a codeword.
    function automatic int unsigned codeword_final_bytes(input int unsigned data_bytes);
        int unsigned tail_bytes;
        tail_bytes = codeword_last_line_bytes(data_bytes) + RS_PARITY_BYTES;
        return tail_bytes - (codeword_tail_lines(data_bytes) - 1) * data_bytes;
    endfunction

endpackage

// File: rtl/rs_codeword_tail_shift.sv
// Tail register: packs the last data line's message bytes with the parity
// bytes, then shifts them out one output line at a time.
module rs_codeword_tail_shift
    import rs_encode_pkg::*;
#(
    parameter int unsigned DATA_W          = 256,
    parameter int unsigned PARITY_W        = 256,
    parameter int unsigned LAST_LINE_BYTES = 31,
    parameter int unsigned FINAL_BYTES     = 31
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [DATA_W-1:0]   line_i,
    input  logic [PARITY_W-1:0] parity_i,
    output logic [DATA_W-1:0]   top_line_o,
    output logic [DATA_W-1:0]   final_mask_o
);

    localparam int unsigned TAIL_W      = DATA_W + PARITY_W;
    localparam int unsigned KEEP_BITS   = LAST_LINE_BYTES * 8;
    localparam int unsigned PAR_SHIFT   = DATA_W - KEEP_BITS;
    localparam logic [DATA_W-1:0] ALL_ONES   = '1;
    localparam logic [DATA_W-1:0] KEEP_MASK  = ~(ALL_ONES >> KEEP_BITS);
    localparam logic [DATA_W-1:0] FINAL_MASK = ~(ALL_ONES >> (FINAL_BYTES * 8));

    logic [TAIL_W-1:0] tail_q;
    logic [TAIL_W-1:0] tail_d;
    logic [TAIL_W-1:0] load_val;

    // Message bytes left-aligned; parity butted directly against them, zero below.
    always_comb begin
        load_val = {line_i & KEEP_MASK, {PARITY_W{1'b0}}}
                 | (TAIL_W'(parity_i) << PAR_SHIFT);
    end

    // Next tail contents: load on absorb, shift one line per accepted beat.
    always_comb begin
        tail_d = tail_q;
        if (load_i) begin
            tail_d = load_val;
        end else if (shift_i) begin
            tail_d = tail_q << DATA_W;
        end
    end

    // Tail register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tail_q <= '0;
        end else begin
            tail_q <= tail_d;
        end
    end

    assign top_line_o   = tail_q[TAIL_W-1 -: DATA_W];
    assign final_mask_o = FINAL_MASK;

endmodule

// File: rtl/rs_codeword_line_pack.sv
// Packs one RS codeword (data lines + parity on the last line) into a dense
// byte stream of DATA_W lines, flagging the final line and its byte count.
module rs_codeword_line_pack
    import rs_encode_pkg::*;
#(
    parameter int unsigned DATA_W       = 256,
    parameter int unsigned DATA_BYTES   = DATA_W / 8,
    parameter int unsigned DATA_BYTES_W = $clog2(DATA_BYTES),
    parameter int unsigned NUM_LINES    = codeword_num_lines(DATA_BYTES),
    parameter int unsigned PARITY_W     = RS_PARITY_BYTES * RS_WORD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    src_pack_line_val,
    input  logic [DATA_W-1:0]       src_pack_line,
    input  logic [PARITY_W-1:0]     src_pack_parity,
    output logic                    pack_src_line_rdy,
    output logic                    pack_dst_line_val,
    output logic [DATA_W-1:0]       pack_dst_line,
    output logic                    pack_dst_last,
    output logic [DATA_BYTES_W:0]   pack_dst_bytes,
    input  logic                    dst_pack_line_rdy,
    output logic [31:0]             pack_codeword_cnt
);

    localparam int unsigned LAST_LINE_BYTES = codeword_last_line_bytes(DATA_BYTES);
    localparam int unsigned TAIL_LINES      = codeword_tail_lines(DATA_BYTES);
    localparam int unsigned FINAL_BYTES     = codeword_final_bytes(DATA_BYTES);
    localparam int unsigned LINE_CNT_W      = $clog2(NUM_LINES + 1);
    localparam int unsigned TAIL_CNT_W      = $clog2(TAIL_LINES + 1);

    localparam logic [LINE_CNT_W-1:0]   LINE_LAST   = LINE_CNT_W'(NUM_LINES - 1);
    localparam logic [TAIL_CNT_W-1:0]   TAIL_LAST   = TAIL_CNT_W'(TAIL_LINES - 1);
    localparam logic [DATA_BYTES_W:0]   BYTES_FULL  = (DATA_BYTES_W + 1)'(DATA_BYTES);
    localparam logic [DATA_BYTES_W:0]   BYTES_FINAL = (DATA_BYTES_W + 1)'(FINAL_BYTES);

    pack_state_e           state_q, state_d;
    logic [LINE_CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic [TAIL_CNT_W-1:0] tail_cnt_q, tail_cnt_d;
    logic [31:0]           cw_cnt_q, cw_cnt_d;

    logic                  absorb;
    logic                  final_beat;
    logic                  tail_load;
    logic                  tail_shift;
    logic [DATA_W-1:0]     tail_top;
    logic [DATA_W-1:0]     final_mask;

    assign absorb     = (state_q == ST_PASS) && (line_cnt_q == LINE_LAST);
    assign final_beat = (state_q == ST_TAIL) && (tail_cnt_q == TAIL_LAST);

    rs_codeword_tail_shift #(
        .DATA_W          (DATA_W),
        .PARITY_W        (PARITY_W),
        .LAST_LINE_BYTES (LAST_LINE_BYTES),
        .FINAL_BYTES     (FINAL_BYTES)
    ) u_tail_shift (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .load_i       (tail_load),
        .shift_i      (tail_shift),
        .line_i       (src_pack_line),
        .parity_i     (src_pack_parity),
        .top_line_o   (tail_top),
        .final_mask_o (final_mask)
    );

    // State register with line/tail/codeword counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_PASS;
            line_cnt_q <= '0;
            tail_cnt_q <= '0;
            cw_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            line_cnt_q <= line_cnt_d;
            tail_cnt_q <= tail_cnt_d;
            cw_cnt_q   <= cw_cnt_d;
        end
    end

    // Next-state: count pass-through lines, absorb the last one, drain the tail.
    always_comb begin
        state_d    = state_q;
        line_cnt_d = line_cnt_q;
        tail_cnt_d = tail_cnt_q;
        cw_cnt_d   = cw_cnt_q;
        tail_load  = 1'b0;
        tail_shift = 1'b0;
        case (state_q)
            ST_PASS: begin
                if (absorb) begin
                    if (src_pack_line_val) begin
                        tail_load  = 1'b1;
                        line_cnt_d = '0;
                        tail_cnt_d = '0;
                        state_d    = ST_TAIL;
                    end
                end else if (src_pack_line_val && dst_pack_line_rdy) begin
                    line_cnt_d = line_cnt_q + 1'b1;
                end
            end
            ST_TAIL: begin
                if (dst_pack_line_rdy) begin
                    tail_shift = 1'b1;
                    if (final_beat) begin
                        state_d    = ST_PASS;
                        tail_cnt_d = '0;
                        cw_cnt_d   = cw_cnt_q + 32'd1;
                    end else begin
                        tail_cnt_d = tail_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_PASS;
        endcase
    end

    // Outputs: zero-latency pass-through, silent absorb cycle, or tail drain.
    always_comb begin
        pack_src_line_rdy = 1'b0;
        pack_dst_line_val = 1'b0;
        pack_dst_line     = '0;
        pack_dst_last     = 1'b0;
        pack_dst_bytes    = BYTES_FULL;
        case (state_q)
            ST_PASS: begin
                if (absorb) begin
                    pack_src_line_rdy = 1'b1;
                end else begin
                    pack_src_line_rdy = dst_pack_line_rdy;
                    pack_dst_line_val = src_pack_line_val;
                    pack_dst_line     = src_pack_line;
                end
            end
            ST_TAIL: begin
                pack_dst_line_val = 1'b1;
                if (final_beat) begin
                    pack_dst_line  = tail_top & final_mask;
                    pack_dst_last  = 1'b1;
                    pack_dst_bytes = BYTES_FINAL;
                end else begin
                    pack_dst_line  = tail_top;
                end
            end
            default: ;
        endcase
    end

    assign pack_codeword_cnt = cw_cnt_q;

endmodule
